// File: rtl/pll_rst_pkg.sv
// ============================================================================
// Module : pll_rst_pkg
// Brief  : Shared state encodings and defaults for the PLL reset sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pll_rst_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_STABILIZE = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RUN       = 3'd3
    } pll_state_e;

    localparam int c_default_sync_stages        = 2;
    localparam int c_default_lock_stable_cycles = 1024;
    localparam int c_default_hold_cycles        = 16;
    localparam int c_default_loss_cnt_w         = 8;

    // Shared dwell counter must hold max(stable, hold)-1; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bit_synchronizer.sv
// ============================================================================
// Module : bit_synchronizer
// Brief  : N-stage flop chain for bringing a single asynchronous bit into clk.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
// ============================================================================
// Module : pll_reset_sequencer
// Brief  : Turns the PLL lock flag into a filtered, held, synchronously
//          released reset and ready flag; counts lock losses while running.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = c_default_sync_stages,
    parameter int LOCK_STABLE_CYCLES = c_default_lock_stable_cycles,
    parameter int HOLD_CYCLES        = c_default_hold_cycles,
    parameter int LOSS_CNT_W         = c_default_loss_cnt_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  soft_rst_req,
    output logic                  rst_out,
    output logic                  ready,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]            state_dbg
);

    localparam int c_cnt_w = cnt_width(LOCK_STABLE_CYCLES, HOLD_CYCLES);

    localparam logic [2:0] c_st_wait_lock = ST_WAIT_LOCK;
    localparam logic [2:0] c_st_stabilize = ST_STABILIZE;
    localparam logic [2:0] c_st_hold      = ST_HOLD;
    localparam logic [2:0] c_st_run       = ST_RUN;

    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD_CYCLES - 1);

    logic                  w_locked_s;
    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic                  w_loss_inc;
    logic                  r_rst_out;
    logic                  r_ready;
    logic [LOSS_CNT_W-1:0] r_loss_cnt;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (locked),
        .o_q (w_locked_s)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_loss_inc  = 1'b0;
        case (r_state)
            c_st_wait_lock: begin
                if (w_locked_s) begin
                    w_state_nxt = c_st_stabilize;
                    w_cnt_nxt   = '0;
                end
            end
            c_st_stabilize: begin
                // A drop here is treated as a glitch, not a counted loss.
                if (!w_locked_s) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = c_st_hold;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_hold: begin
                if (!w_locked_s) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_hold_last) begin
                    w_state_nxt = c_st_run;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_st_run: begin
                // Lock loss takes priority over a coincident soft reset request.
                if (!w_locked_s) begin
                    w_state_nxt = c_st_wait_lock;
                    w_cnt_nxt   = '0;
                    w_loss_inc  = 1'b1;
                end else if (soft_rst_req) begin
                    w_state_nxt = c_st_hold;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = c_st_wait_lock;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs registered from next-state so they change on the same edge as r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_st_wait_lock;
            r_cnt      <= '0;
            r_rst_out  <= 1'b1;
            r_ready    <= 1'b0;
            r_loss_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rst_out <= (w_state_nxt != c_st_run);
            r_ready   <= (w_state_nxt == c_st_run);
            if (w_loss_inc && !(&r_loss_cnt)) begin
                r_loss_cnt <= r_loss_cnt + 1'b1;
            end
        end
    end

    assign rst_out       = r_rst_out;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_loss_cnt;
    assign state_dbg     = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_reset_sequencer.sv
// ============================================================================
// Module : tb_pll_reset_sequencer
// Brief  : Vector table, hand sequences and randomized run against a
//          deadline-based reference model of the reset sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pll_reset_sequencer;

    localparam int SS       = 2;
    localparam int LSC      = 8;
    localparam int HC       = 4;
    localparam int LW       = 2;
    localparam int LOSS_MAX = (1 << LW) - 1;

    logic          clk;
    logic          rst;
    logic          locked;
    logic          soft_rst_req;
    logic          rst_out;
    logic          ready;
    logic [LW-1:0] lock_loss_cnt;
    logic [2:0]    state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES        (SS),
        .LOCK_STABLE_CYCLES (LSC),
        .HOLD_CYCLES        (HC),
        .LOSS_CNT_W         (LW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .locked        (locked),
        .soft_rst_req  (soft_rst_req),
        .rst_out       (rst_out),
        .ready         (ready),
        .lock_loss_cnt (lock_loss_cnt),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: once the synchronized lock is seen high, release is
    // scheduled at a fixed absolute edge; a soft reset reschedules it.
    typedef struct {
        logic [SS-1:0] hist;
        int            t;
        bit            armed;
        int            release_at;
        int            loss;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t c, input logic lk, input logic sr);
        model_t n;
        bit     seen;
        bit     was_ready;
        n         = c;
        seen      = c.hist[SS-1];
        was_ready = c.armed && (c.t >= c.release_at);
        n.hist    = {c.hist[SS-2:0], lk};
        n.t       = c.t + 1;
        if (!seen) begin
            if (was_ready && c.loss < LOSS_MAX) n.loss = c.loss + 1;
            n.armed = 1'b0;
        end else if (!c.armed) begin
            n.armed      = 1'b1;
            n.release_at = n.t + LSC + HC;
        end else if (was_ready && sr) begin
            n.release_at = n.t + HC;
        end
        return n;
    endfunction

    function automatic int exp_ready(input model_t c);
        return (c.armed && c.t >= c.release_at) ? 1 : 0;
    endfunction

    function automatic int exp_state(input model_t c);
        if (!c.armed)                   return 0;
        if (c.t >= c.release_at)        return 3;
        if (c.t >= c.release_at - HC)   return 2;
        return 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m.hist       <= '0;
            m.t          <= 0;
            m.armed      <= 1'b0;
            m.release_at <= 0;
            m.loss       <= 0;
        end else begin
            m <= model_step(m, locked, soft_rst_req);
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endtask

    task automatic chk_all(input string tag, input int st, input int rdy, input int loss);
        chk({tag, "_state"}, int'(state_dbg), st);
        chk({tag, "_ready"}, int'(ready), rdy);
        chk({tag, "_rst_out"}, int'(rst_out), 1 - rdy);
        chk({tag, "_loss"}, int'(lock_loss_cnt), loss);
    endtask

    typedef struct {
        logic lk;
        logic sr;
        int   n;
        int   st;
        int   rdy;
        int   loss;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic lk, input logic sr, input int n, input int st,
                       input int rdy, input int loss);
        vec_t v;
        v.lk = lk; v.sr = sr; v.n = n; v.st = st; v.rdy = rdy; v.loss = loss;
        vecs.push_back(v);
    endtask

    initial begin
        rst          = 1'b1;
        locked       = 1'b0;
        soft_rst_req = 1'b0;

        // Clean lock, loss in RUN, relock, soft reset
        add(1, 0, 14, 2, 0, 0);
        add(1, 0,  1, 3, 1, 0);
        add(0, 0,  2, 3, 1, 0);
        add(0, 0,  1, 0, 0, 1);
        add(1, 0, 15, 3, 1, 1);
        add(1, 1,  1, 2, 0, 1);
        add(1, 0,  3, 2, 0, 1);
        add(1, 0,  1, 3, 1, 1);
        // Loss, then a one-cycle glitch during STABILIZE
        add(0, 0,  3, 0, 0, 2);
        add(1, 0,  5, 1, 0, 2);
        add(0, 0,  1, 1, 0, 2);
        add(1, 0,  1, 1, 0, 2);
        add(1, 0,  1, 0, 0, 2);
        add(1, 0, 12, 2, 0, 2);
        add(1, 0,  1, 3, 1, 2);
        // Soft reset coincident with lock loss: loss wins
        add(0, 0,  2, 3, 1, 2);
        add(0, 1,  1, 0, 0, 3);
        // Further losses saturate the 2-bit counter
        add(1, 0, 15, 3, 1, 3);
        add(0, 0,  3, 0, 0, 3);
        add(1, 0, 15, 3, 1, 3);
        add(0, 0,  3, 0, 0, 3);
        // soft_rst_req during HOLD has no effect on release timing
        add(1, 0, 12, 2, 0, 3);
        add(1, 1,  1, 2, 0, 3);
        add(1, 0,  1, 2, 0, 3);
        add(1, 0,  1, 3, 1, 3);
        // Park mid-HOLD for the async reset sequence
        add(0, 0,  3, 0, 0, 3);
        add(1, 0, 13, 2, 0, 3);

        repeat (3) @(negedge clk);
        chk_all("reset", 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            locked       = vecs[i].lk;
            soft_rst_req = vecs[i].sr;
            repeat (vecs[i].n) @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].rdy, vecs[i].loss);
        end
        soft_rst_req = 1'b0;

        // Async reset between edges while in HOLD
        #2 rst = 1'b1;
        #1 chk_all("async_rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        chk_all("post_rst_hold", 2, 0, 0);
        @(negedge clk);
        chk_all("post_rst_run", 3, 1, 0);

        // Randomized run against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            chk("rnd_state", int'(state_dbg), exp_state(m));
            chk("rnd_ready", int'(ready), exp_ready(m));
            chk("rnd_rst_out", int'(rst_out), 1 - exp_ready(m));
            chk("rnd_loss", int'(lock_loss_cnt), m.loss);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(299) == 0) begin
                rst = 1'b1;
            end
            if ($urandom_range(24) == 0) locked = ~locked;
            soft_rst_req = ($urandom_range(9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the 50→200 MHz PLL wrapper. Consumes its output clock and its asynchronous `locked` flag.
- Produces a clean, synchronously released, active-high reset plus a `ready` flag for the 200 MHz Mandelbrot compute/SRAM-master domain.
- Filters lock glitches, enforces a hold time after lock, re-asserts reset on lock loss, and counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2, flops in the `locked` synchronizer chain (≥2).
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized-high cycles of `locked` required before leaving STABILIZE (≥1).
- HOLD_CYCLES, 16, cycles reset stays asserted after lock is judged stable (≥1).
- LOSS_CNT_W, 8, width of the saturating lock-loss counter.

Ports:
- clk  in  1  200 MHz clock (PLL outclk_0)
- rst  in  1  asynchronous, active-high reset
- locked  in  1  PLL lock flag, asynchronous to clk
- soft_rst_req  in  1  synchronous single-cycle request to re-reset the downstream domain
- rst_out  out  1  synchronous-release, active-high reset to the downstream domain
- ready  out  1  high only in RUN
- lock_loss_cnt  out  LOSS_CNT_W  saturating count of RUN→WAIT_LOCK transitions
- state_dbg  out  3  current FSM state encoding

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is asynchronous, active-high; it asserts immediately and is applied to every flop.
- Reset values:
  - synchronizer flops = 0, state = WAIT_LOCK, counter = 0
  - rst_out = 1, ready = 0, lock_loss_cnt = 0
- Synchronizer: `locked` passes through SYNC_STAGES flops to give `locked_s`. The FSM uses only `locked_s`.
- FSM states: WAIT_LOCK=0, STABILIZE=1, HOLD=2, RUN=3.
- WAIT_LOCK:
  - locked_s=1 → STABILIZE with cnt=0.
- STABILIZE:
  - locked_s=0 → WAIT_LOCK, cnt=0. This is a glitch: no count increment.
  - Otherwise, cnt==LOCK_STABLE_CYCLES-1 → HOLD with cnt=0; else cnt++.
- HOLD:
  - locked_s=0 → WAIT_LOCK, cnt=0.
  - Otherwise, cnt==HOLD_CYCLES-1 → RUN; else cnt++.
  - soft_rst_req here is ignored.
- RUN:
  - locked_s=0 → WAIT_LOCK and lock_loss_cnt++ (saturates at all-ones, never wraps).
  - Otherwise, soft_rst_req=1 → HOLD with cnt=0, and no count increment.
  - If locked_s=0 and soft_rst_req=1 in the same cycle, lock loss wins.
- soft_rst_req outside RUN and HOLD is ignored.
- Output timing:
  - rst_out and ready are dedicated flops driven from next-state: rst_out = (next≠RUN), ready = (next==RUN). This makes them glitch-free and co-timed with the state register.
  - state_dbg is driven directly from the state register.
- Release latency: take the first edge at which `locked` is high as edge 1. The transition to RUN, and therefore rst_out=0 and ready=1, occurs at edge SYNC_STAGES+1+LOCK_STABLE_CYCLES+HOLD_CYCLES.
- Loss latency: take the first edge sampling `locked` low as edge k. rst_out=1 and ready=0 occur at edge k+SYNC_STAGES.
- Counter width: $clog2(max(LOCK_STABLE_CYCLES, HOLD_CYCLES)), minimum 1 bit.
- Reset during any state: outputs return to reset values asynchronously. After rst falls, operation resumes from WAIT_LOCK. The lock-loss counter is also cleared.

Decomposition:
- Shared package, pll_rst_pkg:
  - state enum with the fixed 3-bit encodings above
  - default constants for SYNC_STAGES, LOCK_STABLE_CYCLES, HOLD_CYCLES
- One sub-module, bit_synchronizer: parameterized N-stage flop chain, async active-high reset to 0. Reused elsewhere for CDC of single bits.

Test Plan (all use SYNC_STAGES=2, LOCK_STABLE_CYCLES=8, HOLD_CYCLES=4 unless stated):
- Clean lock: hold rst for 3 cycles, release, then raise locked before edge 1 → rst_out=1 through edge 14; rst_out=0 and ready=1 from edge 15; state_dbg=3.
- Glitch during STABILIZE: locked low for 1 cycle at edge 6 → FSM returns to WAIT_LOCK; rst_out stays 1; lock_loss_cnt stays 0; release occurs 15 edges after locked returns high.
- Lock loss in RUN: drop locked at edge k → rst_out=1 and ready=0 at edge k+2; lock_loss_cnt=1; relock releases again after 15 edges.
- Soft reset: soft_rst_req pulse in RUN → rst_out=1 for exactly 4 cycles, then ready=1; lock_loss_cnt unchanged. Simultaneous soft_rst_req and lock loss → WAIT_LOCK and lock_loss_cnt increments.
- Saturation: with LOSS_CNT_W=2, perform 5 lock-loss events → lock_loss_cnt reads 1, 2, 3, 3, 3.
- Async reset mid-HOLD: assert rst between edges → rst_out=1, ready=0, lock_loss_cnt=0 immediately, before the next edge; state_dbg=0.
